// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use / memory-wait hazard control for the WISC 5-stage pipeline.
// Optional FWD_WB_LATCH_EN: one-entry retired-write latch enabling select 11 (WB forward).
module fwd_hazard_ctrl #(
  parameter int REG_W  = 3,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [NUM_RD-1:0]       id_rd_use,
  input  logic [NUM_RD*REG_W-1:0] id_rd_sel,
  input  logic                    ex_wr_en,
  input  logic [REG_W-1:0]        ex_wr_reg,
  input  logic                    ex_is_load,
  input  logic                    mem_wr_en,
  input  logic [REG_W-1:0]        mem_wr_reg,
  input  logic                    mem_is_load,
  input  logic                    mem_ready,
  input  logic                    wb_wr_en,
  input  logic [REG_W-1:0]        wb_wr_reg,
  output logic [NUM_RD*2-1:0]     fwd_sel_ex,
  output logic                    stall_id,
  output logic                    bubble_ex,
  output logic                    freeze,
  output logic [1:0]              hz_state,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDUSE   = 2'b01,
    ST_MEMWAIT = 2'b10
  } hz_state_e;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic [NUM_RD-1:0][REG_W-1:0] src;
  logic [NUM_RD-1:0]            active;
  logic [NUM_RD-1:0][1:0]       fwd_nxt;
  logic [NUM_RD-1:0][1:0]       fwd_sel_d, fwd_sel_q;
  logic                         ld_use;
  hz_state_e                    state_d, state_q;
  logic [CNT_W-1:0]             cnt_d, cnt_q;

  assign src    = id_rd_sel;
  assign active = {NUM_RD{id_valid}} & id_rd_use;

  // Priority EX > MEM > WB: the youngest producer holds the newest value.
  always_comb begin
    fwd_nxt = '0;
    ld_use  = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (active[i]) begin
        if (ex_wr_en && (ex_wr_reg == src[i])) begin
          fwd_nxt[i] = SEL_EX;
          if (ex_is_load) ld_use = 1'b1;
        end else if (mem_wr_en && (mem_wr_reg == src[i])) begin
          fwd_nxt[i] = SEL_MEM;
`ifdef FWD_WB_LATCH_EN
        end else if (wb_wr_en && (wb_wr_reg == src[i])) begin
          fwd_nxt[i] = SEL_WB;
`endif
        end else begin
          fwd_nxt[i] = SEL_RF;
        end
      end
    end
  end

  assign freeze    = mem_is_load & ~mem_ready;
  assign stall_id  = freeze | ld_use;
  assign bubble_ex = ld_use & ~freeze;

  always_comb begin
    fwd_sel_d = fwd_nxt;
    if (freeze)         fwd_sel_d = fwd_sel_q;
    else if (bubble_ex) fwd_sel_d = '0;

    state_d = ST_RUN;
    if (freeze)      state_d = ST_MEMWAIT;
    else if (ld_use) state_d = ST_LDUSE;

    cnt_d = cnt_q;
    if (stall_id && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      fwd_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fwd_sel_q <= fwd_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fwd_sel_ex = fwd_sel_q;
  assign hz_state   = state_q;
  assign stall_cnt  = cnt_q;

`ifdef FWD_WB_LATCH_EN
  logic                         wb_lat_vld_q;
  logic [REG_W-1:0]             wb_lat_reg_q;
  logic [NUM_RD-1:0][REG_W-1:0] src_ex_q;

  // Capture is suppressed while frozen so the latch stays aligned with the held EX stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_lat_vld_q <= 1'b0;
      wb_lat_reg_q <= '0;
      src_ex_q     <= '0;
    end else if (!freeze) begin
      if (wb_wr_en) begin
        wb_lat_vld_q <= 1'b1;
        wb_lat_reg_q <= wb_wr_reg;
      end
      src_ex_q <= src;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_lat_chk
    a_wb_sel_has_latch : assert property (@(posedge clk) disable iff (!rst_n)
      (fwd_sel_q[g] == SEL_WB) |-> (wb_lat_vld_q && (wb_lat_reg_q == src_ex_q[g])));
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wr_en, wb_wr_reg};
`endif

endmodule
